fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that drives the instruction memory's word address and consumes its combinational read data. It owns the program counter, selects the next PC (sequential, redirect or hold), and registers the fetched word into the IF/ID pipeline register for the decode stage. A boot-wait phase after reset covers the memory's initial load and zeroing; a halt detector freezes fetch on a designated halt word.

Parameters:
ADDR_W, 10, instruction memory word-address width; PC width
DATA_W, 32, instruction word width
BOOT_CYCLES, 4, cycles spent in BOOT before the first fetch (legal range 1..255)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
NOP_WORD, 32'h0000_0000, bubble value presented on if_instruction when if_valid=0

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
stall  input  1  hold PC and IF/ID (decode not ready)
redirect  input  1  taken branch/jump/flush from a later stage
redirect_target  input  ADDR_W  new PC on redirect
imem_address  output  ADDR_W  word address to instruction memory
imem_q  input  DATA_W  combinational read data for imem_address
if_instruction  output  DATA_W  IF/ID instruction register
if_pc  output  ADDR_W  IF/ID PC of if_instruction
if_pc_next  output  ADDR_W  IF/ID if_pc+1 (mod 2^ADDR_W), for link/relative targets
if_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch stopped on HALT_WORD

Behaviour:
- Reset (async, any time, including mid-BOOT/RUN/HALT): pc=0, state=BOOT, boot_cnt=0, if_instruction=NOP_WORD, if_pc=0, if_pc_next=0, if_valid=0, halted=0.
- imem_address = pc in every state (combinational); read latency 0, so imem_q is sampled on the same edge.
- States BOOT, RUN, HALT; 2-bit encoding; all registers are updated on rising CLK edges.
- BOOT: boot_cnt increments each cycle; when boot_cnt==BOOT_CYCLES-1, go to RUN. IF/ID stays as the bubble. stall and redirect are ignored.
- RUN, priority highest first:
  1. redirect=1: pc<=redirect_target; IF/ID<=bubble (if_valid=0, if_instruction=NOP_WORD). Redirect overrides stall.
  2. stall=1: pc and IF/ID hold.
  3. imem_q==HALT_WORD: IF/ID<=(HALT_WORD, pc, pc+1, valid=1); pc holds; halted<=1; go to HALT.
  4. Otherwise: IF/ID<=(imem_q, pc, pc+1, valid=1); pc<=pc+1.
- Wrap-around: pc+1 is mod 2^ADDR_W, so 1023 goes to 0 for ADDR_W=10; no error is flagged.
- HALT: pc is frozen. If stall=0, if_valid<=0 one cycle after entry; if stall=1, IF/ID holds until stall falls. halted stays 1.
  - redirect=1 in HALT (an older in-flight branch resolving): pc<=redirect_target, halted<=0, IF/ID<=bubble, go to RUN.
  - Only redirect or RESET leave HALT.
- Fetch throughput: one instruction per cycle when stall=0 and redirect=0. Redirect penalty: one bubble.

Optional Feature:
FETCH_PERF_COUNT_EN: when defined, adds outputs fetch_count[31:0] and bubble_count[31:0].
- fetch_count increments on every cycle in which IF/ID loads a valid instruction.
- bubble_count increments on every RUN/HALT cycle with stall=0 in which IF/ID loads a bubble.
- Both clear on RESET and wrap at 2^32.
When the macro is undefined, neither the ports nor the logic exist.

Test Plan:
- Reset, imem holds 0x11,0x22,0x33 at 0..2, BOOT_CYCLES=4 -> imem_address=0 and if_valid=0 for 4 cycles; then if_instruction=0x11/0x22/0x33 with if_pc=0/1/2 on consecutive cycles.
- stall high for 3 cycles while if_pc=5 -> imem_address stays 6 and IF/ID holds (if_pc=5) for 3 cycles; fetch of addr 6 follows the cycle after stall falls.
- redirect=1, target=0x200, asserted together with stall=1 -> next cycle pc=0x200 and if_valid=0; the following cycle if_pc=0x200 and if_valid=1.
- pc=1023 with no stall -> if_pc=1023, if_pc_next=0, next fetch address 0.
- HALT_WORD at addr 7 -> if_pc=7 with halted=1; imem_address stays 7; if_valid=0 thereafter; a subsequent redirect to 3 resumes fetch at 3 with halted=0.
- RESET pulse asynchronous to CLK during RUN at pc=0x40 -> all outputs return to reset values immediately; BOOT restarts from boot_cnt=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle: control inputs, imem port, IF/ID outputs
//
// Purpose: groups the fetch unit's handshake and bus signals so that one
// interface connects the design and its environment.
// Signals:
//   stall, redirect, redirect_target : control from later pipeline stages
//   imem_address, imem_q             : instruction memory word address / read data
//   if_instruction, if_pc,
//   if_pc_next, if_valid             : IF/ID pipeline register
//   halted                           : fetch stopped on the halt word
// Modports: master = fetch unit side, slave = pipeline/memory side.

interface fetch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_q;
  logic [DATA_W-1:0] if_instruction;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_next;
  logic              if_valid;
  logic              halted;

  modport master (
    input  stall, redirect, redirect_target, imem_q,
    output imem_address, if_instruction, if_pc, if_pc_next, if_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_target, imem_q,
    input  imem_address, if_instruction, if_pc, if_pc_next, if_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, boot wait and halt detection
//
// Purpose: owns the program counter, drives the instruction memory word
// address, consumes its combinational read data and registers the fetched
// word into the IF/ID pipeline register. After reset it waits BOOT_CYCLES
// cycles for memory initialisation; fetching HALT_WORD freezes the PC until
// a redirect or reset.
// Ports:
//   CLK    : clock, rising edge
//   RESET  : asynchronous active-high reset
//   bus    : fetch_unit_if.master (stall/redirect in, imem port, IF/ID out)
//   fetch_count, bubble_count : performance counters, present only when
//                               FETCH_PERF_COUNT_EN is defined

module fetch_unit #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter int                BOOT_CYCLES = 4,
  parameter logic [DATA_W-1:0] HALT_WORD   = DATA_W'(32'hFFFF_FFFF),
  parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(32'h0000_0000)
) (
  input  logic         CLK,
  input  logic         RESET,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  bubble_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] ifi_q, ifi_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] ifpcn_q, ifpcn_d;
  logic              ifv_q, ifv_d;
  logic              halted_q, halted_d;
  logic              load_valid;
  logic              load_bubble;

  // Wraps naturally at 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 8'd0;
      pc_q       <= '0;
      ifi_q      <= NOP_WORD;
      ifpc_q     <= '0;
      ifpcn_q    <= '0;
      ifv_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      ifi_q      <= ifi_d;
      ifpc_q     <= ifpc_d;
      ifpcn_q    <= ifpcn_d;
      ifv_q      <= ifv_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_d        = pc_q;
    ifi_d       = ifi_q;
    ifpc_d      = ifpc_q;
    ifpcn_d     = ifpcn_q;
    ifv_d       = ifv_q;
    halted_d    = halted_q;
    load_valid  = 1'b0;
    load_bubble = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // Memory is still loading: stall and redirect have no meaning yet.
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.redirect) begin
          // Redirect wins over stall: the younger fetch is squashed anyway.
          pc_d        = bus.redirect_target;
          ifv_d       = 1'b0;
          ifi_d       = NOP_WORD;
          load_bubble = !bus.stall;
        end else if (bus.stall) begin
          // Hold PC and IF/ID.
        end else if (bus.imem_q == HALT_WORD) begin
          // Present the halt word to decode but do not advance past it.
          ifi_d      = HALT_WORD;
          ifpc_d     = pc_q;
          ifpcn_d    = pc_inc;
          ifv_d      = 1'b1;
          halted_d   = 1'b1;
          state_d    = ST_HALT;
          load_valid = 1'b1;
        end else begin
          ifi_d      = bus.imem_q;
          ifpc_d     = pc_q;
          ifpcn_d    = pc_inc;
          ifv_d      = 1'b1;
          pc_d       = pc_inc;
          load_valid = 1'b1;
        end
      end

      ST_HALT: begin
        if (bus.redirect) begin
          // An older branch resolved after the halt word was fetched.
          pc_d        = bus.redirect_target;
          halted_d    = 1'b0;
          ifv_d       = 1'b0;
          ifi_d       = NOP_WORD;
          state_d     = ST_RUN;
          load_bubble = !bus.stall;
        end else if (!bus.stall) begin
          // Halt word consumed by decode; keep feeding bubbles.
          ifv_d       = 1'b0;
          ifi_d       = NOP_WORD;
          load_bubble = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.imem_address   = pc_q;
  assign bus.if_instruction = ifi_q;
  assign bus.if_pc          = ifpc_q;
  assign bus.if_pc_next     = ifpcn_q;
  assign bus.if_valid       = ifv_q;
  assign bus.halted         = halted_q;

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (load_valid) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (load_bubble) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`else
  // Counter enables exist only to feed the optional counters.
  logic unused_perf;
  assign unused_perf = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit

module tb_fetch_unit;

  logic CLK;
  logic RESET;

  fetch_unit_if #(.ADDR_W(10), .DATA_W(32)) bus ();

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  fetch_unit #(
    .ADDR_W(10),
    .DATA_W(32),
    .BOOT_CYCLES(4),
    .HALT_WORD(32'hFFFF_FFFF),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count(fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  logic [31:0] mem [1024];
  assign bus.imem_q = mem[bus.imem_address];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [9:0]  target;
    logic [9:0]  addr;
    logic [31:0] instr;
    logic [9:0]  pc;
    logic [9:0]  pcn;
    logic        valid;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic st, input logic rd, input logic [9:0] tg,
                     input logic [9:0] ad, input logic [31:0] ins,
                     input logic [9:0] p, input logic [9:0] pn,
                     input logic v, input logic h);
    vec_t x;
    x.stall = st; x.redirect = rd; x.target = tg;
    x.addr = ad; x.instr = ins; x.pc = p; x.pcn = pn; x.valid = v; x.halted = h;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] ad, input logic [31:0] ins,
                           input logic [9:0] p, input logic [9:0] pn,
                           input logic v, input logic h);
    check({tag, " imem_address"},   32'(bus.imem_address), 32'(ad));
    check({tag, " if_instruction"}, bus.if_instruction,    ins);
    check({tag, " if_pc"},          32'(bus.if_pc),        32'(p));
    check({tag, " if_pc_next"},     32'(bus.if_pc_next),   32'(pn));
    check({tag, " if_valid"},       32'(bus.if_valid),     32'(v));
    check({tag, " halted"},         32'(bus.halted),       32'(h));
  endtask

  task automatic step(input string tag, input logic st, input logic rd, input logic [9:0] tg,
                      input logic [9:0] ad, input logic [31:0] ins,
                      input logic [9:0] p, input logic [9:0] pn,
                      input logic v, input logic h);
    bus.stall = st;
    bus.redirect = rd;
    bus.redirect_target = tg;
    @(posedge CLK);
    #1;
    check_all(tag, ad, ins, p, pn, v, h);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[7] = 32'hFFFF_FFFF;

    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    RESET = 1'b1;

    // Boot: four bubble cycles at address 0; stall/redirect ignored.
    add(0, 0, 10'h000, 10'd0,    32'h0,          10'd0,    10'd0,    0, 0);
    add(1, 1, 10'h055, 10'd0,    32'h0,          10'd0,    10'd0,    0, 0);
    add(0, 0, 10'h000, 10'd0,    32'h0,          10'd0,    10'd0,    0, 0);
    add(0, 0, 10'h000, 10'd0,    32'h0,          10'd0,    10'd0,    0, 0);
    // Sequential fetch 0..5.
    add(0, 0, 10'h000, 10'd1,    32'h11,         10'd0,    10'd1,    1, 0);
    add(0, 0, 10'h000, 10'd2,    32'h22,         10'd1,    10'd2,    1, 0);
    add(0, 0, 10'h000, 10'd3,    32'h33,         10'd2,    10'd3,    1, 0);
    add(0, 0, 10'h000, 10'd4,    32'h1000_0003,  10'd3,    10'd4,    1, 0);
    add(0, 0, 10'h000, 10'd5,    32'h1000_0004,  10'd4,    10'd5,    1, 0);
    add(0, 0, 10'h000, 10'd6,    32'h1000_0005,  10'd5,    10'd6,    1, 0);
    // Stall three cycles with if_pc=5.
    add(1, 0, 10'h000, 10'd6,    32'h1000_0005,  10'd5,    10'd6,    1, 0);
    add(1, 0, 10'h000, 10'd6,    32'h1000_0005,  10'd5,    10'd6,    1, 0);
    add(1, 0, 10'h000, 10'd6,    32'h1000_0005,  10'd5,    10'd6,    1, 0);
    add(0, 0, 10'h000, 10'd7,    32'h1000_0006,  10'd6,    10'd7,    1, 0);
    // Halt word at 7, stall held once in HALT, then bubbles.
    add(0, 0, 10'h000, 10'd7,    32'hFFFF_FFFF,  10'd7,    10'd8,    1, 1);
    add(1, 0, 10'h000, 10'd7,    32'hFFFF_FFFF,  10'd7,    10'd8,    1, 1);
    add(0, 0, 10'h000, 10'd7,    32'h0,          10'd7,    10'd8,    0, 1);
    add(0, 0, 10'h000, 10'd7,    32'h0,          10'd7,    10'd8,    0, 1);
    // Redirect out of HALT to 3.
    add(0, 1, 10'd3,   10'd3,    32'h0,          10'd7,    10'd8,    0, 0);
    add(0, 0, 10'h000, 10'd4,    32'h1000_0003,  10'd3,    10'd4,    1, 0);
    // Redirect together with stall: redirect wins.
    add(1, 1, 10'h200, 10'h200,  32'h0,          10'd3,    10'd4,    0, 0);
    add(0, 0, 10'h000, 10'h201,  32'h1000_0200,  10'h200,  10'h201,  1, 0);
    // Wrap-around at 1023.
    add(0, 1, 10'd1022, 10'd1022, 32'h0,         10'h200,  10'h201,  0, 0);
    add(0, 0, 10'h000, 10'd1023, 32'h1000_03FE,  10'd1022, 10'd1023, 1, 0);
    add(0, 0, 10'h000, 10'd0,    32'h1000_03FF,  10'd1023, 10'd0,    1, 0);
    add(0, 0, 10'h000, 10'd1,    32'h11,         10'd0,    10'd1,    1, 0);
    // Reach pc=0x40 before the asynchronous reset.
    add(0, 1, 10'h040, 10'h040,  32'h0,          10'd0,    10'd1,    0, 0);
    add(0, 0, 10'h000, 10'h041,  32'h1000_0040,  10'h040,  10'h041,  1, 0);

    #1;
    check_all("reset", 10'd0, 32'h0, 10'd0, 10'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].stall, vecs[i].redirect, vecs[i].target,
           vecs[i].addr, vecs[i].instr, vecs[i].pc, vecs[i].pcn,
           vecs[i].valid, vecs[i].halted);
    end

    // Asynchronous reset in the middle of a RUN cycle.
    #3;
    RESET = 1'b1;
    #1;
    check_all("async_rst", 10'd0, 32'h0, 10'd0, 10'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    check_all("rst_held", 10'd0, 32'h0, 10'd0, 10'd0, 1'b0, 1'b0);
    RESET = 1'b0;

    // Boot must take the full four cycles again.
    for (int i = 0; i < 4; i++) begin
      step($sformatf("reboot%0d", i), 1'b0, 1'b0, 10'd0,
           10'd0, 32'h0, 10'd0, 10'd0, 1'b0, 1'b0);
    end
    step("refetch0", 1'b0, 1'b0, 10'd0, 10'd1, 32'h11, 10'd0, 10'd1, 1'b1, 1'b0);
    step("refetch1", 1'b0, 1'b0, 10'd0, 10'd2, 32'h22, 10'd1, 10'd2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
